// File: rtl/alu_sequencer.sv
// Multi-cycle front end for the 16-bit combinational ALU: multi-bit shifts and
// a shift-add 16x16 multiply, one ALU operation per clock, valid/ready on both sides.
module alu_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_q,
  output logic        rsp_ovf,
  output logic        rsp_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [15:0] alu_q,
  input  logic        alu_overflow,
  input  logic        alu_zero
);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MADD, S_MSHR, S_MDBL, S_RESP} state_t;

  localparam logic [1:0] CMD_SHL = 2'd0;
  localparam logic [1:0] CMD_LSR = 2'd1;
  localparam logic [1:0] CMD_MUL = 2'd3;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_LRS  = 5'b11000;
  localparam logic [4:0] OP_ARS  = 5'b11010;

  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [15:0] val_q, val_d;
  logic [15:0] mc_q, mc_d;
  logic [15:0] mp_q, mp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic        lost_q, lost_d;
  logic [15:0] res_q, res_d;
  logic        rovf_q, rovf_d;
  logic        rzero_q, rzero_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_op_q, alu_op_d;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    val_d    = val_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    lost_d   = lost_q;
    res_d    = res_q;
    rovf_d   = rovf_q;
    rzero_d  = rzero_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d    = req_cmd;
          sticky_d = 1'b0;
          lost_d   = 1'b0;
          if (req_cmd != CMD_MUL) begin
            val_d = req_a;
            cnt_d = req_b[3:0];
            if (req_b[3:0] == 4'd0) begin
              res_d   = req_a;
              rovf_d  = 1'b0;
              rzero_d = (req_a == 16'd0);
              state_d = S_RESP;
            end else begin
              state_d = S_SHIFT;
            end
          end else if (!MUL_EN || req_b == 16'd0) begin
            res_d   = 16'd0;
            rovf_d  = !MUL_EN;
            rzero_d = 1'b1;
            state_d = S_RESP;
          end else begin
            val_d   = 16'd0;
            mc_d    = req_a;
            mp_d    = req_b;
            state_d = req_b[0] ? S_MADD : S_MSHR;
          end
        end
      end
      S_SHIFT: begin
        val_d    = alu_q;
        sticky_d = sticky_q | alu_overflow;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d   = alu_q;
          rovf_d  = sticky_q | alu_overflow;
          rzero_d = (alu_q == 16'd0);
          state_d = S_RESP;
        end
      end
      // A multiplicand that already lost bits makes any further partial product overflow.
      S_MADD: begin
        val_d    = alu_q;
        sticky_d = sticky_q | alu_overflow | lost_q;
        state_d  = S_MSHR;
      end
      S_MSHR: begin
        mp_d = alu_q;
        if (alu_zero) begin
          res_d   = val_q;
          rovf_d  = sticky_q;
          rzero_d = (val_q == 16'd0);
          state_d = S_RESP;
        end else begin
          state_d = S_MDBL;
        end
      end
      S_MDBL: begin
        mc_d    = alu_q;
        lost_d  = lost_q | alu_overflow;
        state_d = mp_q[0] ? S_MADD : S_MSHR;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // ALU drive is registered, so it is derived from the state being entered.
    alu_a_d  = 16'd0;
    alu_b_d  = 16'd0;
    alu_op_d = 5'd0;
    case (state_d)
      S_SHIFT: begin
        alu_b_d = val_d;
        if (cmd_d == CMD_SHL) begin
          alu_op_d = OP_ADD;
          alu_a_d  = val_d;
        end else begin
          alu_op_d = (cmd_d == CMD_LSR) ? OP_LRS : OP_ARS;
        end
      end
      S_MADD: begin
        alu_op_d = OP_ADD;
        alu_a_d  = val_d;
        alu_b_d  = mc_d;
      end
      S_MSHR: begin
        alu_op_d = OP_LRS;
        alu_b_d  = mp_d;
      end
      S_MDBL: begin
        alu_op_d = OP_ADD;
        alu_a_d  = mc_d;
        alu_b_d  = mc_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= 2'd0;
      val_q    <= 16'd0;
      mc_q     <= 16'd0;
      mp_q     <= 16'd0;
      cnt_q    <= 4'd0;
      sticky_q <= 1'b0;
      lost_q   <= 1'b0;
      res_q    <= 16'd0;
      rovf_q   <= 1'b0;
      rzero_q  <= 1'b0;
      alu_a_q  <= 16'd0;
      alu_b_q  <= 16'd0;
      alu_op_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      val_q    <= val_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      lost_q   <= lost_d;
      res_q    <= res_d;
      rovf_q   <= rovf_d;
      rzero_q  <= rzero_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_q     = res_q;
  assign rsp_ovf   = rovf_q;
  assign rsp_zero  = rzero_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule
